// File: rtl/core_pipeline_controller_if.sv
// Pipeline-control bundle between the core datapath and core_pipeline_controller.
// The master modport is the controller side; slave is the datapath/CSR side.
interface core_pipeline_controller_if #(
  parameter int IRQ_NUM = 4
);
  logic               ex_valid;
  logic               id_valid;
  logic [31:0]        if_pc;
  logic [31:0]        id_pc;
  logic [31:0]        ex_next_pc;
  logic               jump_en_ex;
  logic [31:0]        jump_addr_ex;
  logic               exception_returned;
  logic               wait_for_interrupt;
  logic               load_use_hazard;
  logic               mem_busy;
  logic [IRQ_NUM-1:0] irq_pending;
  logic [IRQ_NUM-1:0] irq_enable;
  logic               global_ie;
  logic [31:0]        mtvec;

  logic               hold_pc;
  logic               hold_if_id;
  logic               hold_ex;
  logic               flush_if_id;
  logic               flush_id_ex;
  logic               pc_jump_en;
  logic [31:0]        pc_jump_addr;
  logic               trap_enter;
  logic [31:0]        trap_mepc;
  logic [31:0]        trap_mcause;
  logic               core_sleeping;

  modport master (
    input  ex_valid, id_valid, if_pc, id_pc, ex_next_pc, jump_en_ex, jump_addr_ex,
           exception_returned, wait_for_interrupt, load_use_hazard, mem_busy,
           irq_pending, irq_enable, global_ie, mtvec,
    output hold_pc, hold_if_id, hold_ex, flush_if_id, flush_id_ex, pc_jump_en,
           pc_jump_addr, trap_enter, trap_mepc, trap_mcause, core_sleeping
  );

  modport slave (
    output ex_valid, id_valid, if_pc, id_pc, ex_next_pc, jump_en_ex, jump_addr_ex,
           exception_returned, wait_for_interrupt, load_use_hazard, mem_busy,
           irq_pending, irq_enable, global_ie, mtvec,
    input  hold_pc, hold_if_id, hold_ex, flush_if_id, flush_id_ex, pc_jump_en,
           pc_jump_addr, trap_enter, trap_mepc, trap_mcause, core_sleeping
  );
endinterface

// File: rtl/core_pipeline_controller.sv
// Hold/flush/redirect sequencer for the three-stage core, including interrupt
// arbitration, one-cycle trap entry and WFI sleep.
module core_pipeline_controller #(
  parameter int IRQ_NUM        = 4,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  core_pipeline_controller_if.master ctl
);

  typedef enum logic [1:0] {RUN, SLEEP, TRAP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        cause_q, cause_d;
  logic [31:0]        resume_q, resume_d;
  logic [IRQ_NUM-1:0] irq_masked;
  logic               irq_hit;
  logic [30:0]        irq_code;

  assign irq_masked = ctl.irq_pending & ctl.irq_enable;
  assign irq_hit    = |irq_masked;

  // Walk downwards so the lowest asserted line is the one that sticks.
  always_comb begin
    irq_code = 31'(IRQ_CAUSE_BASE);
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (irq_masked[i]) irq_code = 31'(IRQ_CAUSE_BASE + i);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      mepc_q   <= '0;
      cause_q  <= '0;
      resume_q <= '0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      cause_q  <= cause_d;
      resume_q <= resume_d;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    mepc_d            = mepc_q;
    cause_d           = cause_q;
    resume_d          = resume_q;
    ctl.hold_pc       = 1'b0;
    ctl.hold_if_id    = 1'b0;
    ctl.hold_ex       = 1'b0;
    ctl.flush_if_id   = 1'b0;
    ctl.flush_id_ex   = 1'b0;
    ctl.pc_jump_en    = 1'b0;
    ctl.pc_jump_addr  = '0;
    ctl.trap_enter    = 1'b0;
    ctl.trap_mepc     = '0;
    ctl.trap_mcause   = '0;
    ctl.core_sleeping = 1'b0;

    if (rst) begin
      ctl.flush_if_id = 1'b1;
      ctl.flush_id_ex = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ctl.mem_busy) begin
            ctl.hold_pc    = 1'b1;
            ctl.hold_if_id = 1'b1;
            ctl.hold_ex    = 1'b1;
          end else if (ctl.global_ie && irq_hit && !ctl.exception_returned) begin
            // EX commits this cycle, so mepc is where it would have gone next.
            mepc_d = ctl.ex_valid ? (ctl.jump_en_ex ? ctl.jump_addr_ex : ctl.ex_next_pc)
                                  : (ctl.id_valid ? ctl.id_pc : ctl.if_pc);
            cause_d         = {1'b1, irq_code};
            ctl.flush_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
            ctl.hold_pc     = 1'b1;
            state_d         = TRAP;
          end else if (ctl.ex_valid && ctl.jump_en_ex) begin
            ctl.pc_jump_en   = 1'b1;
            ctl.pc_jump_addr = ctl.jump_addr_ex;
            ctl.flush_if_id  = 1'b1;
            ctl.flush_id_ex  = 1'b1;
          end else if (ctl.ex_valid && ctl.wait_for_interrupt) begin
            resume_d        = ctl.ex_next_pc;
            ctl.hold_pc     = 1'b1;
            ctl.hold_if_id  = 1'b1;
            ctl.flush_id_ex = 1'b1;
            state_d         = SLEEP;
          end else if (ctl.load_use_hazard) begin
            ctl.hold_pc     = 1'b1;
            ctl.hold_if_id  = 1'b1;
            ctl.flush_id_ex = 1'b1;
          end
        end

        SLEEP: begin
          ctl.core_sleeping = 1'b1;
          ctl.hold_pc       = 1'b1;
          ctl.hold_if_id    = 1'b1;
          ctl.flush_id_ex   = 1'b1;
          if (irq_hit) begin
            if (ctl.global_ie) begin
              mepc_d  = resume_q;
              cause_d = {1'b1, irq_code};
              state_d = TRAP;
            end else begin
              state_d = RUN;
            end
          end
        end

        TRAP: begin
          ctl.trap_enter   = 1'b1;
          ctl.trap_mepc    = mepc_q;
          ctl.trap_mcause  = cause_q;
          ctl.pc_jump_en   = 1'b1;
          ctl.flush_if_id  = 1'b1;
          ctl.flush_id_ex  = 1'b1;
          // Vectored mode offsets the base by 4 * cause code.
          ctl.pc_jump_addr = (ctl.mtvec[1:0] == 2'b01)
                           ? {ctl.mtvec[31:2], 2'b00} + {cause_q[29:0], 2'b00}
                           : {ctl.mtvec[31:2], 2'b00};
          state_d          = RUN;
        end

        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_core_pipeline_controller.sv
// Directed bench for core_pipeline_controller: a vector table for single-cycle
// RUN decisions plus hand-written trap, WFI and reset sequences.
module tb_core_pipeline_controller;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  core_pipeline_controller_if #(.IRQ_NUM(4)) bus ();

  core_pipeline_controller #(
    .IRQ_NUM(4),
    .IRQ_CAUSE_BASE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctl(bus)
  );

  // Flag order: hold_pc hold_if_id hold_ex flush_if_id flush_id_ex pc_jump_en trap_enter core_sleeping
  function automatic logic [7:0] flags();
    return {bus.hold_pc, bus.hold_if_id, bus.hold_ex, bus.flush_if_id,
            bus.flush_id_ex, bus.pc_jump_en, bus.trap_enter, bus.core_sleeping};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ex_valid           = 1'b0;
    bus.id_valid           = 1'b0;
    bus.if_pc              = 32'h0000_0010;
    bus.id_pc              = 32'h0000_000c;
    bus.ex_next_pc         = 32'h0;
    bus.jump_en_ex         = 1'b0;
    bus.jump_addr_ex       = 32'h0;
    bus.exception_returned = 1'b0;
    bus.wait_for_interrupt = 1'b0;
    bus.load_use_hazard    = 1'b0;
    bus.mem_busy           = 1'b0;
    bus.irq_pending        = 4'b0;
    bus.irq_enable         = 4'b0;
    bus.global_ie          = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        ex_valid;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        exc_ret;
    logic        wfi;
    logic        lu;
    logic        busy;
    logic [3:0]  irq_p;
    logic [3:0]  irq_e;
    logic        gie;
    logic [7:0]  exp_flags;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"idle",        0, 0, 32'h0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"branch",      1, 1, 32'h100, 0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_11_1_00, 32'h100});
    vecs.push_back('{"load_use",    0, 0, 32'h0,   0, 0, 1, 0, 4'h0, 4'h0, 0, 8'b110_01_0_00, 32'h0});
    vecs.push_back('{"lu_cleared",  0, 0, 32'h0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"lu_busy",     0, 0, 32'h0,   0, 0, 1, 1, 4'h0, 4'h0, 0, 8'b111_00_0_00, 32'h0});
    vecs.push_back('{"busy_irq",    1, 0, 32'h0,   0, 0, 0, 1, 4'h1, 4'h1, 1, 8'b111_00_0_00, 32'h0});
    vecs.push_back('{"after_busy",  0, 0, 32'h0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"branch_lu",   1, 1, 32'h240, 0, 0, 1, 0, 4'h0, 4'h0, 0, 8'b000_11_1_00, 32'h240});
    vecs.push_back('{"mret_irq",    1, 1, 32'h400, 1, 0, 0, 0, 4'h4, 4'hf, 1, 8'b000_11_1_00, 32'h400});
    vecs.push_back('{"after_mret",  0, 0, 32'h0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"irq_no_gie",  1, 0, 32'h0,   0, 0, 0, 0, 4'hf, 4'hf, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"irq_masked",  1, 0, 32'h0,   0, 0, 0, 0, 4'hf, 4'h0, 1, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"jump_bubble", 0, 1, 32'h500, 0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"wfi_bubble",  0, 0, 32'h0,   0, 1, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});
    vecs.push_back('{"final_idle",  0, 0, 32'h0,   0, 0, 0, 0, 4'h0, 4'h0, 0, 8'b000_00_0_00, 32'h0});

    // Reset overrides everything, even an active redirect request.
    rst = 1'b1;
    idle_inputs();
    bus.mtvec      = 32'h0000_1000;
    bus.ex_valid   = 1'b1;
    bus.jump_en_ex = 1'b1;
    bus.jump_addr_ex = 32'h0000_0abc;
    @(negedge clk);
    #1;
    check("reset_flags", 32'(flags()), 32'(8'b000_11_0_00));
    check("reset_jump_addr", bus.pc_jump_addr, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();

    foreach (vecs[k]) begin
      bus.ex_valid           = vecs[k].ex_valid;
      bus.jump_en_ex         = vecs[k].jump_en;
      bus.jump_addr_ex       = vecs[k].jump_addr;
      bus.exception_returned = vecs[k].exc_ret;
      bus.wait_for_interrupt = vecs[k].wfi;
      bus.load_use_hazard    = vecs[k].lu;
      bus.mem_busy           = vecs[k].busy;
      bus.irq_pending        = vecs[k].irq_p;
      bus.irq_enable         = vecs[k].irq_e;
      bus.global_ie          = vecs[k].gie;
      #1;
      check({vecs[k].name, "_flags"}, 32'(flags()), 32'(vecs[k].exp_flags));
      check({vecs[k].name, "_addr"}, bus.pc_jump_addr, vecs[k].exp_addr);
      tick();
    end
    idle_inputs();

    // Interrupt in RUN, direct mode.
    bus.ex_valid    = 1'b1;
    bus.ex_next_pc  = 32'h204;
    bus.irq_pending = 4'b0110;
    bus.irq_enable  = 4'b1111;
    bus.global_ie   = 1'b1;
    bus.mtvec       = 32'h1000;
    #1;
    check("irq_capture_flags", 32'(flags()), 32'(8'b100_11_0_00));
    tick();
    idle_inputs();
    #1;
    check("irq_trap_flags", 32'(flags()), 32'(8'b000_11_1_10));
    check("irq_trap_mepc", bus.trap_mepc, 32'h204);
    check("irq_trap_mcause", bus.trap_mcause, 32'h8000_0011);
    check("irq_trap_addr", bus.pc_jump_addr, 32'h1000);
    tick();
    #1;
    check("irq_after_trap", 32'(flags()), 32'(8'b0));

    // Same interrupt, vectored mtvec.
    bus.ex_valid    = 1'b1;
    bus.ex_next_pc  = 32'h204;
    bus.irq_pending = 4'b0110;
    bus.irq_enable  = 4'b1111;
    bus.global_ie   = 1'b1;
    bus.mtvec       = 32'h1001;
    tick();
    idle_inputs();
    #1;
    check("vec_trap_addr", bus.pc_jump_addr, 32'h1044);
    check("vec_trap_mcause", bus.trap_mcause, 32'h8000_0011);
    tick();
    bus.mtvec = 32'h1000;

    // Jump plus interrupt: mepc is the jump target, no redirect this cycle.
    bus.ex_valid     = 1'b1;
    bus.jump_en_ex   = 1'b1;
    bus.jump_addr_ex = 32'h300;
    bus.ex_next_pc   = 32'h208;
    bus.irq_pending  = 4'b1000;
    bus.irq_enable   = 4'b1000;
    bus.global_ie    = 1'b1;
    #1;
    check("jirq_capture_flags", 32'(flags()), 32'(8'b100_11_0_00));
    tick();
    idle_inputs();
    #1;
    check("jirq_trap_mepc", bus.trap_mepc, 32'h300);
    check("jirq_trap_mcause", bus.trap_mcause, 32'h8000_0013);
    tick();

    // WFI then wake with interrupts enabled.
    bus.ex_valid           = 1'b1;
    bus.wait_for_interrupt = 1'b1;
    bus.ex_next_pc         = 32'h80;
    #1;
    check("wfi_entry_flags", 32'(flags()), 32'(8'b110_01_0_00));
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      bus.mem_busy = (i == 2);
      #1;
      check($sformatf("sleep_idle_%0d", i), 32'(flags()), 32'(8'b110_01_0_01));
      tick();
    end
    idle_inputs();
    bus.irq_pending = 4'b0001;
    bus.irq_enable  = 4'b0001;
    bus.global_ie   = 1'b1;
    #1;
    check("sleep_wake_flags", 32'(flags()), 32'(8'b110_01_0_01));
    tick();
    idle_inputs();
    #1;
    check("wfi_trap_flags", 32'(flags()), 32'(8'b000_11_1_10));
    check("wfi_trap_mepc", bus.trap_mepc, 32'h80);
    check("wfi_trap_mcause", bus.trap_mcause, 32'h8000_0010);
    tick();

    // WFI woken with global_ie clear: straight back to RUN, no trap.
    bus.ex_valid           = 1'b1;
    bus.wait_for_interrupt = 1'b1;
    bus.ex_next_pc         = 32'h90;
    tick();
    idle_inputs();
    bus.irq_pending = 4'b0001;
    bus.irq_enable  = 4'b0001;
    #1;
    check("wfi_noie_sleep", 32'(flags()), 32'(8'b110_01_0_01));
    tick();
    idle_inputs();
    #1;
    check("wfi_noie_run", 32'(flags()), 32'(8'b0));
    tick();
    #1;
    check("wfi_noie_no_trap", 32'(flags()), 32'(8'b0));

    // Reset in the middle of TRAP.
    bus.ex_valid    = 1'b1;
    bus.ex_next_pc  = 32'h600;
    bus.irq_pending = 4'b0010;
    bus.irq_enable  = 4'b0010;
    bus.global_ie   = 1'b1;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_in_trap_flags", 32'(flags()), 32'(8'b000_11_0_00));
    tick();
    rst = 1'b0;
    #1;
    check("rst_after_trap", 32'(flags()), 32'(8'b0));
    check("rst_after_trap_mepc", bus.trap_mepc, 32'h0);

    // Reset while sleeping.
    bus.ex_valid           = 1'b1;
    bus.wait_for_interrupt = 1'b1;
    bus.ex_next_pc         = 32'hA0;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_after_sleep", 32'(flags()), 32'(8'b0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
